// File: rtl/fifo_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fifo_sched_pkg : shared types and defaults for the FIFO port scheduler
// Revision       : 1.0
// ============================================================================
package fifo_sched_pkg;

  localparam int NUM_WR_DEF = 4;
  localparam int DEPTH_DEF  = 16;
  localparam int DW_DEF     = 8;

  typedef enum logic [0:0] {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin picker, search starts at ptr
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_WR = 4
) (
  input  logic [NUM_WR-1:0]         req,
  input  logic [$clog2(NUM_WR)-1:0] ptr,
  output logic [NUM_WR-1:0]         gnt,
  output logic [$clog2(NUM_WR)-1:0] next_ptr
);

  localparam int PW = $clog2(NUM_WR);

  logic [PW-1:0] idx;
  logic          hit;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    hit      = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_WR);
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((int'(idx) + 1) % NUM_WR);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_port_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fifo_port_sched : shares a single-op-per-cycle FIFO between NUM_WR writers
//                   and one reader; optional checker via FIFO_PORT_SCHED_CHECK_EN
// Revision        : 1.0
// ============================================================================
module fifo_port_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_WR = NUM_WR_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*DW-1:0]         wr_data,
  output logic [NUM_WR-1:0]            wr_gnt,
  input  logic                         rd_req,
  output logic                         rd_gnt,
  output logic [DW-1:0]                rd_data,
  output logic                         rd_vld,
  output logic                         fifo_rst,
  output logic                         fifo_wr,
  output logic                         fifo_rd,
  output logic [DW-1:0]                fifo_din,
  input  logic [DW-1:0]                fifo_dout,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic [occ_width(DEPTH)-1:0]  occ,
  output logic                         err
);

  localparam int             OW      = occ_width(DEPTH);
  localparam int             PW      = $clog2(NUM_WR);
  localparam logic [OW-1:0]  OCC_MAX = OW'(DEPTH);

  sched_state_e   state_q, state_d;
  logic [OW-1:0]  occ_q, occ_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           last_rd_q, last_rd_d;
  logic           fifo_wr_q, fifo_wr_d;
  logic           fifo_rd_q, fifo_rd_d;
  logic [DW-1:0]  fifo_din_q, fifo_din_d;
  logic           rd_vld_q, rd_vld_d;

  logic [NUM_WR-1:0] arb_gnt;
  logic [PW-1:0]     arb_next_ptr;
  logic [DW-1:0]     sel_data;
  logic              wr_ok, rd_ok, do_wr, do_rd;

  rr_arbiter #(
    .NUM_WR (NUM_WR)
  ) u_arb (
    .req      (wr_req),
    .ptr      (rr_ptr_q),
    .gnt      (arb_gnt),
    .next_ptr (arb_next_ptr)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (arb_gnt[i]) sel_data = sel_data | wr_data[i*DW +: DW];
    end
  end

  assign wr_ok = (|wr_req) && (occ_q != OCC_MAX);
  assign rd_ok = rd_req && (occ_q != '0);

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    rr_ptr_d   = rr_ptr_q;
    last_rd_d  = last_rd_q;
    fifo_wr_d  = 1'b0;
    fifo_rd_d  = 1'b0;
    fifo_din_d = fifo_din_q;
    rd_vld_d   = fifo_rd_q;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    wr_gnt     = '0;
    rd_gnt     = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        state_d  = ST_RUN;
        occ_d    = '0;
        rd_vld_d = 1'b0;
      end
      ST_RUN: begin
        if (flush) begin
          state_d  = ST_FLUSH;
          occ_d    = '0;
          rd_vld_d = 1'b0;
        end else begin
          // Under contention the slot alternates, starting with a read.
          if (wr_ok && rd_ok) begin
            do_rd = !last_rd_q;
            do_wr = last_rd_q;
          end else begin
            do_rd = rd_ok;
            do_wr = wr_ok;
          end
          if (do_wr) begin
            wr_gnt     = arb_gnt;
            rr_ptr_d   = arb_next_ptr;
            fifo_wr_d  = 1'b1;
            fifo_din_d = sel_data;
            occ_d      = occ_q + OW'(1);
            last_rd_d  = 1'b0;
          end
          if (do_rd) begin
            rd_gnt    = 1'b1;
            fifo_rd_d = 1'b1;
            occ_d     = occ_q - OW'(1);
            last_rd_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FLUSH;
      occ_q      <= '0;
      rr_ptr_q   <= '0;
      last_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_din_q <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      rr_ptr_q   <= rr_ptr_d;
      last_rd_q  <= last_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_din_q <= fifo_din_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  assign fifo_rst = (state_q == ST_FLUSH);
  assign fifo_wr  = fifo_wr_q;
  assign fifo_rd  = fifo_rd_q;
  assign fifo_din = fifo_din_q;
  assign rd_vld   = rd_vld_q;
  assign rd_data  = fifo_dout;
  assign occ      = occ_q;

`ifdef FIFO_PORT_SCHED_CHECK_EN
  logic err_q, err_d;
  logic occ_zero_dly_q, occ_zero_dly_d;
  logic run_dly_q, run_dly_d;
  logic run_now;

  assign run_now = (state_q == ST_RUN);

  // The FIFO's empty flag trails the mirror count by one cycle.
  always_comb begin
    err_d          = err_q;
    occ_zero_dly_d = (occ_q == '0);
    run_dly_d      = run_now;
    if (fifo_wr_q && fifo_full)  err_d = 1'b1;
    if (fifo_rd_q && fifo_empty) err_d = 1'b1;
    if (run_now && run_dly_q && (occ_zero_dly_q != fifo_empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q          <= 1'b0;
      occ_zero_dly_q <= 1'b0;
      run_dly_q      <= 1'b0;
    end else begin
      err_q          <= err_d;
      occ_zero_dly_q <= occ_zero_dly_d;
      run_dly_q      <= run_dly_d;
    end
  end

  assign err = err_q;
`else
  logic unused_flags;
  assign unused_flags = ^{fifo_full, fifo_empty};
  assign err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_port_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fifo_port_sched : random stimulus against a queue-based reference model
// Revision           : 1.0
// ============================================================================
module tb_fifo_port_sched;

  localparam int NUM_WR = 4;
  localparam int DEPTH  = 16;
  localparam int DW     = 8;
  localparam int OW     = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [NUM_WR-1:0]    wr_req = '0;
  logic [NUM_WR*DW-1:0] wr_data = '0;
  logic [NUM_WR-1:0]    wr_gnt;
  logic                 rd_req = 1'b0;
  logic                 rd_gnt;
  logic [DW-1:0]        rd_data;
  logic                 rd_vld;
  logic                 fifo_rst, fifo_wr, fifo_rd;
  logic [DW-1:0]        fifo_din;
  logic [DW-1:0]        fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic [OW-1:0]        occ;
  logic                 err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_port_sched #(.NUM_WR(NUM_WR), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_vld(rd_vld),
    .fifo_rst(fifo_rst), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_din(fifo_din), .fifo_dout(fifo_dout),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .occ(occ), .err(err)
  );

  // Behavioural 16-deep FIFO: one op per cycle, write wins, sync reset wins.
  logic [DW-1:0] mem [DEPTH];
  logic [4:0]    f_cnt  = '0;
  logic [3:0]    f_wp   = '0;
  logic [3:0]    f_rp   = '0;
  logic [DW-1:0] f_dout = '0;

  always @(posedge clk) begin
    if (fifo_rst) begin
      f_cnt <= '0; f_wp <= '0; f_rp <= '0;
    end else if (fifo_wr) begin
      mem[f_wp] <= fifo_din; f_wp <= f_wp + 4'd1; f_cnt <= f_cnt + 5'd1;
    end else if (fifo_rd) begin
      f_dout <= mem[f_rp]; f_rp <= f_rp + 4'd1; f_cnt <= f_cnt - 5'd1;
    end
  end

  assign fifo_full  = (f_cnt == 5'(DEPTH));
  assign fifo_empty = (f_cnt == 5'd0);
  assign fifo_dout  = f_dout;

  // Reference model state.
  bit          m_run, m_last_rd, m_fwr, m_frd, m_vld;
  int          m_occ, m_ptr;
  logic [7:0]  m_fdin, m_vdata, m_pend;
  logic [7:0]  m_q[$];
  bit          w_req[NUM_WR];
  logic [7:0]  w_dat[NUM_WR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_last_rd = 0; m_fwr = 0; m_frd = 0; m_vld = 0;
    m_occ = 0; m_ptr = 0; m_fdin = '0; m_vdata = '0; m_pend = '0;
    m_q.delete();
  endtask

  task automatic check_reset_state();
    check("rst_fifo_rst", fifo_rst, 1);
    check("rst_occ",      occ,      0);
    check("rst_wr_gnt",   wr_gnt,   0);
    check("rst_rd_gnt",   rd_gnt,   0);
    check("rst_fifo_wr",  fifo_wr,  0);
    check("rst_fifo_rd",  fifo_rd,  0);
    check("rst_fifo_din", fifo_din, 0);
    check("rst_rd_vld",   rd_vld,   0);
    check("rst_err",      err,      0);
  endtask

  task automatic drive(input int pw, input int pr, input int pf);
    for (int i = 0; i < NUM_WR; i++) begin
      if (!w_req[i] && $urandom_range(99) < pw) begin
        w_req[i] = 1'b1;
        w_dat[i] = 8'($urandom);
      end
      wr_req[i] = w_req[i];
      wr_data[i*DW +: DW] = w_dat[i];
    end
    rd_req = ($urandom_range(99) < pr);
    flush  = ($urandom_range(999) < pf);
  endtask

  // Called mid-cycle: compare DUT against the model, then advance the model.
  task automatic step();
    int   gi;
    bit   gr, any_w, wok, rok, dw, dr, nv;
    logic [7:0] nvd;
    logic [NUM_WR-1:0] exp_wg;
    gi = -1; gr = 0; any_w = 0; dw = 0; dr = 0;
    for (int i = 0; i < NUM_WR; i++) if (w_req[i]) any_w = 1;
    if (m_run && !flush) begin
      wok = any_w && (m_occ < DEPTH);
      rok = rd_req && (m_occ > 0);
      if (wok && rok) begin dr = !m_last_rd; dw = m_last_rd; end
      else begin dr = rok; dw = wok; end
      if (dw) begin
        for (int k = 0; k < NUM_WR; k++) begin
          int j;
          j = (m_ptr + k) % NUM_WR;
          if (gi < 0 && w_req[j]) gi = j;
        end
      end
      gr = dr;
    end
    exp_wg = '0;
    if (gi >= 0) exp_wg[gi] = 1'b1;

    check("fifo_rst", fifo_rst, !m_run);
    check("wr_gnt",   wr_gnt,   exp_wg);
    check("rd_gnt",   rd_gnt,   gr);
    check("occ",      occ,      m_occ);
    check("fifo_wr",  fifo_wr,  m_fwr);
    check("fifo_rd",  fifo_rd,  m_frd);
    check("wr_rd_excl", fifo_wr & fifo_rd, 0);
    if (m_fwr) check("fifo_din", fifo_din, m_fdin);
    check("rd_vld",   rd_vld,   m_vld);
    if (m_vld) check("rd_data", rd_data, m_vdata);
    check("err",      err,      0);

    nv  = m_frd && m_run && !flush;
    nvd = m_pend;
    m_vld = nv; m_vdata = nvd;
    m_fwr = (gi >= 0);
    m_frd = gr;
    if (gi >= 0) begin
      m_fdin = w_dat[gi];
      m_q.push_back(w_dat[gi]);
      m_ptr = (gi + 1) % NUM_WR;
      m_occ++;
      m_last_rd = 0;
      w_req[gi] = 0;
    end
    if (gr) begin
      m_pend = m_q.pop_front();
      m_occ--;
      m_last_rd = 1;
    end
    if (!m_run) begin
      m_run = 1; m_occ = 0;
    end else if (flush) begin
      m_run = 0; m_occ = 0; m_q.delete();
    end
  endtask

  task automatic run_cycles(input int n, input int pw, input int pr, input int pf);
    repeat (n) begin
      @(posedge clk); #1;
      drive(pw, pr, pf);
      @(negedge clk);
      step();
    end
  endtask

  task automatic release_reset(input int pw);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(pw, 0, 0);
    @(negedge clk);
    step();
  endtask

  initial begin
    for (int i = 0; i < NUM_WR; i++) begin w_req[i] = 0; w_dat[i] = '0; end
    model_reset();
    drive(100, 100, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();

    release_reset(100);
    run_cycles(30, 100, 0, 0);   // fill to full, round-robin order
    run_cycles(30, 0, 100, 0);   // drain to empty, then starved reads
    run_cycles(40, 100, 100, 0); // contention from empty
    run_cycles(20, 100, 0, 0);   // refill to full
    run_cycles(60, 90, 60, 0);   // reads free slots at full
    run_cycles(400, 50, 50, 15); // mixed with flushes

    // Asynchronous reset in the middle of traffic.
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    model_reset();
    repeat (2) @(posedge clk);
    release_reset(60);
    run_cycles(250, 60, 60, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
